// File: rtl/cdb_arbiter_if.sv
// Common-data-bus arbiter bundle: unit request side plus registered broadcast side.
// master = functional units / consumers, slave = the arbiter.
interface cdb_arbiter_if #(
  parameter int unsigned N_UNITS = 3,
  parameter int unsigned CDB_W   = 32
);
  localparam int unsigned IdW = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;

  logic [N_UNITS*CDB_W-1:0] i_cdb;
  logic [N_UNITS-1:0]       i_valid;
  logic [N_UNITS-1:0]       i_ready;
  logic                     flush;
  logic [CDB_W-1:0]         o_cdb;
  logic                     o_valid;
  logic [IdW-1:0]           o_grant_id;

  modport master (
    output i_cdb, i_valid, flush,
    input  i_ready, o_cdb, o_valid, o_grant_id
  );

  modport slave (
    input  i_cdb, i_valid, flush,
    output i_ready, o_cdb, o_valid, o_grant_id
  );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: grants at most one completing unit per cycle (round-robin or fixed
// priority with a starvation guard) and broadcasts its word on a registered bus.
module cdb_arbiter #(
  parameter int unsigned N_UNITS  = 3,
  parameter int unsigned CDB_W    = 32,
  parameter int unsigned RR_MODE  = 1,
  parameter int unsigned MAX_WAIT = 4
) (
  input logic           clk,
  input logic           nrst,
  cdb_arbiter_if.slave  bus
);
  localparam int unsigned IdW  = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
  localparam int unsigned AgeW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  logic [N_UNITS-1:0] w_valid;
  logic [N_UNITS-1:0] w_urgent;
  logic [N_UNITS-1:0] w_grant;
  logic [IdW-1:0]     w_rr_id;
  logic [IdW-1:0]     w_fp_id;
  logic [IdW-1:0]     w_gid;
  logic [IdW-1:0]     w_ptr_nxt;
  logic               w_rr_found;
  logic               w_any;
  int unsigned        w_idx;

  logic [IdW-1:0]     r_ptr;
  logic [AgeW-1:0]    r_age [N_UNITS];
  logic [CDB_W-1:0]   r_cdb;
  logic               r_valid;
  logic [IdW-1:0]     r_grant_id;

  // Lowest set index of a request vector (0 when empty; callers gate on emptiness).
  function automatic logic [IdW-1:0] lowest_idx(input logic [N_UNITS-1:0] v);
    logic [IdW-1:0] res;
    res = '0;
    for (int i = N_UNITS - 1; i >= 0; i--) begin
      if (v[i]) res = IdW'(i);
    end
    return res;
  endfunction

  assign w_valid = bus.i_valid;

  // Round-robin search starting at the pointer and wrapping modulo N_UNITS.
  always_comb begin
    w_rr_id    = '0;
    w_rr_found = 1'b0;
    w_idx      = 0;
    for (int unsigned i = 0; i < N_UNITS; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= N_UNITS) w_idx = w_idx - N_UNITS;
      if (!w_rr_found && w_valid[w_idx]) begin
        w_rr_found = 1'b1;
        w_rr_id    = IdW'(w_idx);
      end
    end
  end

  // Fixed priority: an urgent (starved) unit pre-empts the plain lowest-index winner.
  always_comb begin
    w_urgent = '0;
    for (int unsigned i = 0; i < N_UNITS; i++) begin
      w_urgent[i] = (MAX_WAIT != 0) && w_valid[i] && (r_age[i] == AgeW'(MAX_WAIT));
    end
    w_fp_id = (|w_urgent) ? lowest_idx(w_urgent) : lowest_idx(w_valid);
  end

  // Final one-hot grant; suppressed during flush and while reset is held.
  always_comb begin
    w_any     = (|w_valid) && !bus.flush && nrst;
    w_gid     = (RR_MODE != 0) ? w_rr_id : w_fp_id;
    w_grant   = w_any ? (N_UNITS'(1) << w_gid) : '0;
    w_ptr_nxt = (w_gid == IdW'(N_UNITS - 1)) ? '0 : w_gid + IdW'(1);
  end

  assign bus.i_ready = w_grant;

  // Round-robin pointer advances past the unit just granted.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_ptr <= '0;
    end else if (w_any && (RR_MODE != 0)) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // Age counters track consecutive lost cycles per unit; only meaningful in fixed priority.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int unsigned k = 0; k < N_UNITS; k++) r_age[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < N_UNITS; k++) begin
        if ((RR_MODE != 0) || bus.flush || !w_valid[k] || w_grant[k]) begin
          r_age[k] <= '0;
        end else if (r_age[k] < AgeW'(MAX_WAIT)) begin
          r_age[k] <= r_age[k] + AgeW'(1);
        end
      end
    end
  end

  // Broadcast register: word and id hold when idle, valid pulses for one cycle per grant.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_valid    <= 1'b0;
      r_cdb      <= '0;
      r_grant_id <= '0;
    end else begin
      r_valid <= w_any;
      if (w_any) begin
        r_cdb      <= bus.i_cdb[int'(w_gid)*CDB_W +: CDB_W];
        r_grant_id <= w_gid;
      end
    end
  end

  assign bus.o_cdb      = r_cdb;
  assign bus.o_valid    = r_valid;
  assign bus.o_grant_id = r_grant_id;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: round-robin, fixed priority with and without the
// starvation guard, flush behaviour and asynchronous reset in mid-stream.
module tb_cdb_arbiter;
  localparam int unsigned N = 3;
  localparam int unsigned W = 32;

  logic clk;
  logic nrst;

  cdb_arbiter_if #(.N_UNITS(N), .CDB_W(W)) if_rr  ();
  cdb_arbiter_if #(.N_UNITS(N), .CDB_W(W)) if_fp4 ();
  cdb_arbiter_if #(.N_UNITS(N), .CDB_W(W)) if_fp0 ();

  cdb_arbiter #(.N_UNITS(N), .CDB_W(W), .RR_MODE(1), .MAX_WAIT(4)) u_rr (
    .clk(clk), .nrst(nrst), .bus(if_rr)
  );
  cdb_arbiter #(.N_UNITS(N), .CDB_W(W), .RR_MODE(0), .MAX_WAIT(4)) u_fp4 (
    .clk(clk), .nrst(nrst), .bus(if_fp4)
  );
  cdb_arbiter #(.N_UNITS(N), .CDB_W(W), .RR_MODE(0), .MAX_WAIT(0)) u_fp0 (
    .clk(clk), .nrst(nrst), .bus(if_fp0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int       sel;     // 0 = round-robin, 1 = fixed MAX_WAIT=4, 2 = fixed MAX_WAIT=0
    logic [2:0] valid;
    logic       flush;
    logic [2:0] ready;   // expected grant this cycle
    logic       ovalid;  // expected registered outputs (previous cycle's grant)
    logic [1:0] gid;
    logic       chk_cdb;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;
  int   row   = 0;

  function automatic logic [W-1:0] word(input int k);
    return 32'hC0DE_0000 + 32'(k) * 32'h0000_1111;
  endfunction

  task automatic add(input int sel, input logic [2:0] v, input logic f, input logic [2:0] r,
                     input logic ov, input logic [1:0] g, input logic c);
    vec_t x;
    x.sel = sel; x.valid = v; x.flush = f; x.ready = r;
    x.ovalid = ov; x.gid = g; x.chk_cdb = c;
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic [2:0] v, input logic f);
    if_rr.i_valid  = (sel == 0) ? v : 3'b000;
    if_rr.flush    = (sel == 0) ? f : 1'b0;
    if_fp4.i_valid = (sel == 1) ? v : 3'b000;
    if_fp4.flush   = (sel == 1) ? f : 1'b0;
    if_fp0.i_valid = (sel == 2) ? v : 3'b000;
    if_fp0.flush   = (sel == 2) ? f : 1'b0;
  endtask

  task automatic check_row(input vec_t x);
    logic [2:0]   rdy;
    logic         ov;
    logic [1:0]   gid;
    logic [W-1:0] cdb;
    case (x.sel)
      0:       begin rdy = if_rr.i_ready;  ov = if_rr.o_valid;  gid = if_rr.o_grant_id;
                     cdb = if_rr.o_cdb;  end
      1:       begin rdy = if_fp4.i_ready; ov = if_fp4.o_valid; gid = if_fp4.o_grant_id;
                     cdb = if_fp4.o_cdb; end
      default: begin rdy = if_fp0.i_ready; ov = if_fp0.o_valid; gid = if_fp0.o_grant_id;
                     cdb = if_fp0.o_cdb; end
    endcase
    check("i_ready", W'(rdy), W'(x.ready));
    check("o_valid", W'(ov), W'(x.ovalid));
    check("o_grant_id", W'(gid), W'(x.gid));
    if (x.chk_cdb) check("o_cdb", cdb, word(int'(x.gid)));
  endtask

  initial begin
    logic [N*W-1:0] words;
    for (int k = 0; k < N; k++) words[k*W +: W] = word(k);
    if_rr.i_cdb  = words;
    if_fp4.i_cdb = words;
    if_fp0.i_cdb = words;
    drive(0, 3'b000, 1'b0);
    nrst = 1'b0;

    // Round-robin: six-cycle rotation, wrap from ptr=2, flush with unchanged ptr.
    add(0, 3'b111, 0, 3'b001, 0, 0, 0);
    add(0, 3'b111, 0, 3'b010, 1, 0, 1);
    add(0, 3'b111, 0, 3'b100, 1, 1, 1);
    add(0, 3'b111, 0, 3'b001, 1, 2, 1);
    add(0, 3'b111, 0, 3'b010, 1, 0, 1);
    add(0, 3'b111, 0, 3'b100, 1, 1, 1);
    add(0, 3'b010, 0, 3'b010, 1, 2, 1);
    add(0, 3'b001, 0, 3'b001, 1, 1, 1);
    add(0, 3'b000, 0, 3'b000, 1, 0, 1);
    add(0, 3'b000, 0, 3'b000, 0, 0, 1);
    add(0, 3'b011, 1, 3'b000, 0, 0, 1);
    add(0, 3'b011, 0, 3'b010, 0, 0, 1);
    add(0, 3'b001, 0, 3'b001, 1, 1, 1);
    add(0, 3'b000, 1, 3'b000, 1, 0, 1);
    add(0, 3'b000, 0, 3'b000, 0, 0, 1);
    // Fixed priority, MAX_WAIT=4: unit 2 wins on its 5th waiting cycle; flush resets age.
    add(1, 3'b101, 0, 3'b001, 0, 0, 0);
    add(1, 3'b101, 0, 3'b001, 1, 0, 1);
    add(1, 3'b101, 0, 3'b001, 1, 0, 1);
    add(1, 3'b101, 0, 3'b001, 1, 0, 1);
    add(1, 3'b101, 0, 3'b100, 1, 0, 1);
    add(1, 3'b001, 0, 3'b001, 1, 2, 1);
    add(1, 3'b000, 0, 3'b000, 1, 0, 1);
    add(1, 3'b000, 0, 3'b000, 0, 0, 1);
    add(1, 3'b101, 0, 3'b001, 0, 0, 1);
    add(1, 3'b101, 0, 3'b001, 1, 0, 1);
    add(1, 3'b101, 0, 3'b001, 1, 0, 1);
    add(1, 3'b101, 1, 3'b000, 1, 0, 1);
    add(1, 3'b101, 0, 3'b001, 0, 0, 1);
    add(1, 3'b101, 0, 3'b001, 1, 0, 1);
    add(1, 3'b101, 0, 3'b001, 1, 0, 1);
    add(1, 3'b101, 0, 3'b001, 1, 0, 1);
    add(1, 3'b101, 0, 3'b100, 1, 0, 1);
    add(1, 3'b001, 0, 3'b001, 1, 2, 1);
    add(1, 3'b000, 0, 3'b000, 1, 0, 1);
    // Fixed priority, guard disabled: unit 1 starves until unit 0 leaves.
    add(2, 3'b011, 0, 3'b001, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(2, 3'b011, 0, 3'b001, 1, 0, 1);
    add(2, 3'b010, 0, 3'b010, 1, 0, 1);
    add(2, 3'b000, 0, 3'b000, 1, 1, 1);
    add(2, 3'b000, 0, 3'b000, 0, 1, 1);

    repeat (2) @(negedge clk);
    nrst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      row = i;
      @(negedge clk);
      drive(vecs[i].sel, vecs[i].valid, vecs[i].flush);
      #1;
      check_row(vecs[i]);
    end

    // Async reset mid-broadcast on the round-robin instance (ptr is 1 here).
    row = 1000;
    @(negedge clk);
    drive(0, 3'b111, 1'b0);
    @(posedge clk);
    #2;
    check("pre_rst o_valid", W'(if_rr.o_valid), W'(1'b1));
    check("pre_rst o_cdb", if_rr.o_cdb, word(1));
    @(posedge clk);
    #2;
    nrst = 1'b0;
    #1;
    check("rst o_valid", W'(if_rr.o_valid), W'(1'b0));
    check("rst o_cdb", if_rr.o_cdb, '0);
    check("rst o_grant_id", W'(if_rr.o_grant_id), '0);
    check("rst i_ready", W'(if_rr.i_ready), '0);
    @(negedge clk);
    nrst = 1'b1;
    #1;
    check("post_rst i_ready", W'(if_rr.i_ready), W'(3'b001));
    @(posedge clk);
    #1;
    check("post_rst o_valid", W'(if_rr.o_valid), W'(1'b1));
    check("post_rst o_grant_id", W'(if_rr.o_grant_id), '0);
    check("post_rst o_cdb", if_rr.o_cdb, word(0));
    @(negedge clk);
    drive(0, 3'b000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Parametrised common-data-bus arbiter for the out-of-order core. It collects completed results from N functional units, including the ALU, the memory functional unit and the MMU return path. Each cycle it grants at most one unit and broadcasts the granted word on a registered CDB for exactly one cycle to the reorder buffer, reservation stations and operand bypass. It replaces the fixed-priority combinational CDB mux in the core with three additions:
- selectable round-robin or fixed-priority arbitration;
- starvation protection in fixed-priority mode;
- a flush input for branch-miss recovery.

## Interface
- N_UNITS, 3, number of requesting units, 2..16
- CDB_W, fcpu_pkg::CDB_W, width of one CDB word ({rsv_id, data})
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (lowest index wins)
- MAX_WAIT, 4, fixed-priority starvation limit in cycles; 0 disables the guard; ignored when RR_MODE=1

Ports:
- clk  in  1  core clock
- nrst  in  1  asynchronous, active-low reset
- i_cdb  in  N_UNITS*CDB_W  result words, unit k at [k*CDB_W +: CDB_W]
- i_valid  in  N_UNITS  unit k holds a result
- i_ready  out  N_UNITS  one-hot-or-zero grant, combinational from i_valid, ptr, age counters and flush
- flush  in  1  branch-miss flush
- o_cdb  out  CDB_W  registered broadcast word
- o_valid  out  1  o_cdb is valid this cycle; the bus has no backpressure
- o_grant_id  out  max(1,$clog2(N_UNITS))  index of the unit whose word is on o_cdb

## Operation
- Transfer: unit k transfers on a cycle where i_valid[k] && i_ready[k]. A unit must hold i_valid and i_cdb stable until it transfers. Units drop i_valid on the cycle after their last transfer.
- At most one i_ready bit is high per cycle. i_ready is all-zero when i_valid is zero or flush is high.
- Round-robin (RR_MODE=1):
  - Pointer ptr ranges 0..N_UNITS-1.
  - Search order is ptr, ptr+1, …, wrapping modulo N_UNITS. The first valid unit wins.
  - After a grant to unit g, ptr <= (g+1) mod N_UNITS. With no grant, ptr is unchanged.
- Fixed priority (RR_MODE=0):
  - Each unit has an age counter of width $clog2(MAX_WAIT+1).
  - The counter increments while i_valid[k] && !i_ready[k], saturating at MAX_WAIT.
  - The counter clears on grant, on !i_valid[k], or on flush.
  - A unit whose counter == MAX_WAIT (MAX_WAIT>0) is urgent. If any unit is urgent, the lowest-index urgent unit wins. Otherwise the lowest-index valid unit wins.
- Output register: on a grant, o_cdb <= i_cdb[g], o_grant_id <= g, o_valid <= 1. With no grant, o_valid <= 0 and o_cdb/o_grant_id hold their values.
- Flush:
  - No grant in the flush cycle.
  - o_valid <= 0 in the next cycle.
  - Age counters clear; ptr is unchanged.
  - A word already on o_cdb in the flush cycle still shows o_valid=1 that cycle; consumers qualify it with their own flush logic.
- N_UNITS=1: the unit is granted whenever valid; ptr stays 0.

## Timing
- Reset (nrst low, asynchronous): o_valid=0, o_cdb=0, o_grant_id=0, ptr=0, all age counters 0. i_ready is forced to zero while nrst is low.
- Latency: a grant in cycle t appears as o_valid=1 and o_cdb in cycle t+1, for exactly one cycle.
- Throughput: one word per cycle. Back-to-back grants produce o_valid high on consecutive cycles.
- Simultaneous requests: exactly one winner per the mode rules. Losers keep i_valid and are considered again next cycle.
- Wrap-around: with ptr=N_UNITS-1 and requests only at lower indices, the search wraps and grants the lowest valid index.
- Reset release is synchronised externally. The first grant can occur in the first cycle with nrst high.
- Reset asserted mid-broadcast: o_valid drops immediately, asynchronously.

## Test plan
- RR, N_UNITS=3: all three i_valid held high 6 cycles -> grants 0,1,2,0,1,2; o_grant_id lags by one cycle; o_valid high 6 consecutive cycles.
- RR wrap: ptr=2 (after granting 1), only i_valid[0] high -> grant 0; ptr becomes 1; o_cdb = i_cdb[0] next cycle.
- Fixed, MAX_WAIT=4: unit 0 valid every cycle, unit 2 valid continuously -> unit 2 counter reaches 4 after 4 losses; unit 2 granted on the 5th cycle; unit 0 granted again after.
- Fixed, MAX_WAIT=0: units 0 and 1 always valid -> unit 1 never granted; counters stay 0.
- Flush: units 0 and 1 valid, flush high one cycle -> i_ready=0 that cycle; o_valid=0 the next cycle; the following cycle resumes from an unchanged ptr.
- Async reset mid-stream: nrst low during back-to-back broadcasts -> o_valid=0 and o_cdb=0 immediately; after release, the first grant goes to unit 0 (ptr=0).
